aes128_inv_cipher: RTL and testbench
====================================

Name: aes128_inv_cipher

Overview:
- Iterative AES-128 inverse cipher: accepts one 128-bit ciphertext block and returns the plaintext after 10 cycles.
- Performs one round per clock: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
- Round keys come from an external, already-expanded key store via an index/data lookup.
- Sits on the decrypt path, opposite the team's encryption round logic, and uses the same state byte layout.

Parameters:
- NR, 10, number of rounds (fixed for AES-128; index width derived from it)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ciphertext block offered
- in_ready  out  1  block accepted when in_valid && in_ready
- ciphertext  in  [0:127]  input block, bit 0 = MSB
- rk_idx  out  4  round-key index requested (0..10)
- rk  in  [0:127]  round key for rk_idx, combinational same-cycle return
- out_valid  out  1  plaintext available
- out_ready  in  1  consumer accepts when out_valid && out_ready
- plaintext  out  [0:127]  result block

Behaviour:
- State layout: byte k = bits [8k:8k+7]. Bytes 4r..4r+3 form row r (row-major). Column c = bytes {c, 4+c, 8+c, 12+c}.
- InvShiftRows: row r rotated RIGHT by r bytes. Row 1 {b4,b5,b6,b7} becomes {b7,b4,b5,b6}.
- InvMixColumns: per column, GF(2^8) matrix {0e,0b,0d,09}, polynomial 0x11b.
- Reset (async): FSM=IDLE, in_ready=1, out_valid=0, plaintext=0, rk_idx=10, round counter=0, state register=0.
- FSM states: IDLE, ROUND, FINAL, DONE.
  - IDLE: in_ready=1, rk_idx=10. On handshake, state <= ciphertext ^ rk, cnt <= 9, go to ROUND.
  - ROUND: rk_idx=cnt. state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk). cnt decrements. When cnt==1, go to FINAL.
  - FINAL: rk_idx=0. plaintext <= InvSubBytes(InvShiftRows(state)) ^ rk. out_valid <= 1, go to DONE.
  - DONE: out_valid=1, plaintext held stable. On out_ready, out_valid <= 0 and go to IDLE.
- Latency: with the input handshake at edge E0, out_valid is high from edge E10 (rounds at E1..E9, final at E10).
- Throughput without the optional feature: one block per 12 cycles minimum (IDLE cycle required between blocks).
- in_ready=0 in ROUND/FINAL/DONE. in_valid is ignored outside IDLE; ciphertext needs to be stable only on the handshake cycle.
- rk is sampled only on the cycle rk_idx drives its value; the key store must not change keys mid-block.
- Reset mid-block: the block is discarded with no partial output. The next block after reset is processed normally.
- out_ready asserted while out_valid=0: no effect.

Optional Feature:
- AES_INV_CIPHER_BACK2BACK_EN defined:
  - In DONE, in_ready = out_ready and rk_idx = 10.
  - If an output handshake and an input handshake occur in the same cycle, the new block loads and the FSM goes directly to ROUND; out_valid drops.
  - Sustained throughput: 1 block / 11 cycles.
- Undefined: DONE always returns to IDLE, and in_ready=0 in DONE.

Decomposition:
- Package aes_pkg:
  - state_t (logic [0:127])
  - NR=10
  - rk_idx_t (logic [3:0])
  - FSM enum inv_state_e
  - gf_mul functions (xtime, mul9/11/13/14)
  - inv_shift_rows function (pure wiring, same layout as encrypt side)
- Sub-module aes_inv_sbox: 8-bit combinational lookup table, instantiated 16×.

Test Plan:
- FIPS-197 C.1: key 000102..0f expanded by the bench; ct 69c4e0d86a7b0430d8cdb78070b4c55a transposed to row-major -> plaintext = 00112233..ff transposed; out_valid exactly 10 cycles after accept; rk_idx sequence 10,9,..,1,0.
- Backpressure: out_ready held 0 for 20 cycles -> out_valid stays 1, plaintext unchanged, in_ready=0 throughout; release -> out_valid falls next edge, in_ready=1.
- Reset at ROUND cnt=5 -> immediate out_valid=0, plaintext=0, in_ready=1; next block (FIPS vector) decrypts correctly.
- Round trip: 1000 random key/plaintext pairs through a bench encryption model in the same layout -> decrypted result equals original.
- in_valid pulses while busy -> ignored; only blocks accepted with in_ready=1 are produced, in order, with no duplicates.
- AES_INV_CIPHER_BACK2BACK_EN: continuous in_valid/out_ready with 8 blocks -> accept every 11 cycles, 8 correct outputs; undefined build -> every 12 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types, FSM encoding and GF(2^8) helpers for the AES-128 inverse cipher.
// State layout: byte k = bits [8k:8k+7], row-major (byte 4r+c is row r, column c).
package aes_pkg;

    localparam int NR   = 10;
    localparam int RK_W = $clog2(NR + 1);

    typedef logic [0:127]      state_t;
    typedef logic [RK_W-1:0]   rk_idx_t;

    localparam rk_idx_t LAST_RK = rk_idx_t'(NR);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } inv_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] mul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // Row r rotates right by r bytes: output column c takes input column (c - r) mod 4.
    function automatic state_t inv_shift_rows(input state_t s);
        state_t r;
        for (int row = 0; row < 4; row++) begin
            for (int col = 0; col < 4; col++) begin
                r[8*(4*row + col) +: 8] = s[8*(4*row + ((col - row + 4) % 4)) +: 8];
            end
        end
        return r;
    endfunction

    function automatic state_t inv_mix_columns(input state_t s);
        state_t     r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[8*c        +: 8];
            a1 = s[8*(4 + c)  +: 8];
            a2 = s[8*(8 + c)  +: 8];
            a3 = s[8*(12 + c) +: 8];
            r[8*c        +: 8] = mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3);
            r[8*(4 + c)  +: 8] = mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3);
            r[8*(8 + c)  +: 8] = mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3);
            r[8*(12 + c) +: 8] = mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes128_inv_cipher_if.sv
// Block handshake plus round-key lookup bundle between the inverse cipher and its environment.
interface aes128_inv_cipher_if;
    import aes_pkg::*;

    logic    in_valid;
    logic    in_ready;
    state_t  ciphertext;
    rk_idx_t rk_idx;
    state_t  rk;
    logic    out_valid;
    logic    out_ready;
    state_t  plaintext;

    modport master (
        output in_valid, ciphertext, rk, out_ready,
        input  in_ready, rk_idx, out_valid, plaintext
    );

    modport slave (
        input  in_valid, ciphertext, rk, out_ready,
        output in_ready, rk_idx, out_valid, plaintext
    );
endinterface

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box: one byte in, one byte out, pure combinational table lookup.
module aes_inv_sbox (
    input  logic [7:0] value,
    output logic [7:0] inv_value
);
    localparam logic [0:2047] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign inv_value = INV_SBOX[{value, 3'b000} +: 8];
endmodule

// File: rtl/aes128_inv_cipher.sv
// Iterative AES-128 inverse cipher, one round per clock, round keys fetched by index.
// Define AES_INV_CIPHER_BACK2BACK_EN to let a new block load in the same cycle the result is taken.
module aes128_inv_cipher
    import aes_pkg::*;
(
    input logic            clk,
    input logic            rst_n,
    aes128_inv_cipher_if.slave bus
);
    inv_state_e fsm_reg, fsm_next;
    state_t     state_reg, state_next;
    state_t     plaintext_reg, plaintext_next;
    rk_idx_t    cnt_reg, cnt_next;
    logic       out_valid_reg, out_valid_next;

    state_t     shifted, subbed, keyed, mixed;

    assign shifted = inv_shift_rows(state_reg);

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
            aes_inv_sbox u_sbox (
                .value     (shifted[8*gi +: 8]),
                .inv_value (subbed[8*gi +: 8])
            );
        end
    endgenerate

    assign keyed = subbed ^ bus.rk;
    assign mixed = inv_mix_columns(keyed);

    assign bus.out_valid = out_valid_reg;
    assign bus.plaintext = plaintext_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg       <= IDLE;
            state_reg     <= '0;
            cnt_reg       <= '0;
            plaintext_reg <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            fsm_reg       <= fsm_next;
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            plaintext_reg <= plaintext_next;
            out_valid_reg <= out_valid_next;
        end
    end

    always_comb begin
        fsm_next       = fsm_reg;
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        plaintext_next = plaintext_reg;
        out_valid_next = out_valid_reg;
        bus.in_ready   = 1'b0;
        bus.rk_idx     = LAST_RK;

        case (fsm_reg)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = bus.ciphertext ^ bus.rk;
                    cnt_next   = LAST_RK - rk_idx_t'(1);
                    fsm_next   = ROUND;
                end
            end
            ROUND: begin
                bus.rk_idx = cnt_reg;
                state_next = mixed;
                cnt_next   = cnt_reg - rk_idx_t'(1);
                if (cnt_reg == rk_idx_t'(1)) begin
                    fsm_next = FINAL;
                end
            end
            FINAL: begin
                bus.rk_idx     = '0;
                plaintext_next = keyed;
                out_valid_next = 1'b1;
                fsm_next       = DONE;
            end
            DONE: begin
`ifdef AES_INV_CIPHER_BACK2BACK_EN
                // Accepting a new block is only allowed when the result leaves this same cycle.
                bus.in_ready = bus.out_ready;
                if (bus.out_ready) begin
                    out_valid_next = 1'b0;
                    if (bus.in_valid) begin
                        state_next = bus.ciphertext ^ bus.rk;
                        cnt_next   = LAST_RK - rk_idx_t'(1);
                        fsm_next   = ROUND;
                    end else begin
                        fsm_next = IDLE;
                    end
                end
`else
                if (bus.out_ready) begin
                    out_valid_next = 1'b0;
                    fsm_next       = IDLE;
                end
`endif
            end
            default: begin
                fsm_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_aes128_inv_cipher.sv
// Scoreboard bench for aes128_inv_cipher: directed FIPS-197 vector, backpressure, reset, random round trips.
module tb_aes128_inv_cipher;
`ifdef AES_INV_CIPHER_BACK2BACK_EN
    localparam int EXP_GAP = 11;
`else
    localparam int EXP_GAP = 12;
`endif
    localparam logic [127:0] FIPS_KEY    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT_COL = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT_COL = 128'h00112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int pass_cnt = 0;
    int total_cnt = 0;
    int out_cnt = 0;
    int cyc = 0;

    logic [127:0] rk_table [16];
    logic [127:0] exp_q [$];
    logic [7:0]   sbox_t [256];
    logic [127:0] exp_val;

    aes128_inv_cipher_if bus ();

    aes128_inv_cipher dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Key store: combinational lookup by the requested index.
    assign bus.rk = rk_table[bus.rk_idx];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} >> (8 - n);
        return t[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Column-major FIPS byte order to the row-major state layout.
    function automatic logic [127:0] to_rows(input logic [127:0] v);
        logic [127:0] s;
        for (int i = 0; i < 16; i++)
            s[127 - 8*(4*(i % 4) + i / 4) -: 8] = v[127 - 8*i -: 8];
        return s;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc = 8'h01;
        logic [127:0] k;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) begin
            k = '0;
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    k[127 - 8*(4*row + c) -: 8] = w[4*r + c][31 - 8*row -: 8];
            rk_table[r] = k;
        end
    endtask

    // Forward cipher in the same row-major layout, using the current key store.
    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [127:0] s, t;
        logic [7:0]   a0, a1, a2, a3;
        s = pt ^ rk_table[0];
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) s[127 - 8*k -: 8] = sbox_t[s[127 - 8*k -: 8]];
            t = s;
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    s[127 - 8*(4*row + col) -: 8] = t[127 - 8*(4*row + (col + row) % 4) -: 8];
            if (r != 10) begin
                t = s;
                for (int c = 0; c < 4; c++) begin
                    a0 = t[127 - 8*c -: 8];
                    a1 = t[127 - 8*(4 + c) -: 8];
                    a2 = t[127 - 8*(8 + c) -: 8];
                    a3 = t[127 - 8*(12 + c) -: 8];
                    s[127 - 8*c -: 8]        = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[127 - 8*(4 + c) -: 8]  = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[127 - 8*(8 + c) -: 8]  = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[127 - 8*(12 + c) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            s ^= rk_table[r];
        end
        return s;
    endfunction

    task automatic send(input logic [127:0] ct, input logic [127:0] pt, input string name);
        bit ok = 1'b0;
        bus.ciphertext = ct;
        bus.in_valid   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) exp_q.push_back(pt);
        check(name, 128'(ok), 128'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && bus.in_ready && !bus.out_valid) begin
                done = 1'b1;
                break;
            end
        end
        check(name, 128'(done), 128'd1);
    endtask

    // Monitor: every output handshake pops one expected block.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_output: got %h, required no output", bus.plaintext);
            end else begin
                exp_val = exp_q.pop_front();
                out_cnt++;
                $display("out %0d plaintext=%h", out_cnt, bus.plaintext);
                check("plaintext", bus.plaintext, exp_val);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, required self-termination");
        $fatal(1);
    end

    logic [127:0] fips_ct, fips_pt, pt, ct, key;
    logic [127:0] blk_pt [8];
    logic [127:0] blk_ct [8];
    int acc [8];
    int lat, bad_ov, bad_pt, bad_ir, busy_ir, k, ov_wait;

    initial begin
        for (int i = 0; i < 16; i++) rk_table[i] = '0;
        bus.in_valid   = 1'b0;
        bus.ciphertext = '0;
        bus.out_ready  = 1'b0;
        build_sbox();
        fips_ct = to_rows(FIPS_CT_COL);
        fips_pt = to_rows(FIPS_PT_COL);
        expand_key(FIPS_KEY);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_in_ready", 128'(bus.in_ready), 128'd1);
        check("rst_plaintext", bus.plaintext, 128'd0);
        check("rst_rk_idx", 128'(bus.rk_idx), 128'd10);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 C.1 with latency and key-index sequence
        bus.ciphertext = fips_ct;
        bus.in_valid   = 1'b1;
        @(negedge clk);
        check("fips_accept", 128'(bus.in_ready), 128'd1);
        check("fips_idx_idle", 128'(bus.rk_idx), 128'd10);
        exp_q.push_back(fips_pt);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i < 10) check($sformatf("fips_idx_%0d", i), 128'(bus.rk_idx), 128'(9 - i));
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
        check("fips_latency", 128'(lat), 128'd10);
        wait_drain("fips_drain");

        // Backpressure: result must hold while out_ready is low
        bus.out_ready = 1'b0;
        send(fips_ct, fips_pt, "bp_accept");
        ov_wait = 0;
        for (int i = 0; i < 30 && !bus.out_valid; i++) begin
            @(negedge clk);
            ov_wait++;
        end
        check("bp_valid_seen", 128'(bus.out_valid), 128'd1);
        bad_ov = 0; bad_pt = 0; bad_ir = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1) bad_ov++;
            if (bus.plaintext !== fips_pt) bad_pt++;
            if (bus.in_ready !== 1'b0) bad_ir++;
        end
        check("bp_valid_drops", 128'(bad_ov), 128'd0);
        check("bp_plaintext_changes", 128'(bad_pt), 128'd0);
        check("bp_in_ready_high", 128'(bad_ir), 128'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 128'(bus.out_valid), 128'd0);
        check("bp_release_ready", 128'(bus.in_ready), 128'd1);
        wait_drain("bp_drain");

        // Reset in the middle of a block
        send(fips_ct, fips_pt, "rst_mid_accept");
        repeat (4) @(posedge clk);
        #1;
        check("rst_mid_idx", 128'(bus.rk_idx), 128'd5);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_mid_plaintext", bus.plaintext, 128'd0);
        check("rst_mid_in_ready", 128'(bus.in_ready), 128'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(fips_ct, fips_pt, "post_rst_accept");
        wait_drain("post_rst_drain");

        // in_valid pulses while busy must be ignored
        pt = 128'h0123456789abcdeffedcba9876543210;
        ct = encrypt(pt);
        send(fips_ct, fips_pt, "busy_first_accept");
        busy_ir = 0;
        for (int i = 0; i < 8; i++) begin
            bus.ciphertext = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
            bus.in_valid   = 1'(i % 2);
            @(negedge clk);
            if (bus.in_ready !== 1'b0) busy_ir++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("busy_in_ready", 128'(busy_ir), 128'd0);
        wait_drain("busy_drain1");
        send(ct, pt, "busy_second_accept");
        wait_drain("busy_drain2");

        // Random round trips through the bench encryption model
        for (int n = 0; n < 1000; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            expand_key(key);
            ct = encrypt(pt);
            send(ct, pt, "rt_accept");
            wait_drain("rt_drain");
        end

        // Streaming throughput with a fixed key
        expand_key(FIPS_KEY);
        for (int i = 0; i < 8; i++) begin
            blk_pt[i] = {$urandom, $urandom, $urandom, $urandom};
            blk_ct[i] = encrypt(blk_pt[i]);
        end
        k = 0;
        bus.in_valid   = 1'b1;
        bus.ciphertext = blk_ct[0];
        for (int c = 0; c < 200 && k < 8; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(blk_pt[k]);
                acc[k] = cyc;
                k++;
            end
            @(posedge clk); #1;
            if (k < 8) bus.ciphertext = blk_ct[k];
            else bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        check("stream_accepted", 128'(k), 128'd8);
        for (int i = 1; i < k; i++)
            check($sformatf("stream_gap_%0d", i), 128'(acc[i] - acc[i-1]), 128'(EXP_GAP));
        wait_drain("stream_drain");

        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
